// File: rtl/tt_signature_reader.sv
// Exhaustive truth-table reader: walks every input vector of a single-output netlist,
// packs the sampled outputs LSB-first into words on a valid/ready stream and counts the onset.
module tt_signature_reader #(
  parameter int N_IN   = 15,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     ones_count
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  word_nxt;
  logic [IDX_W-1:0]   idx;
  logic               last_bit;
  logic               last_vec;

  assign idx      = x_out[IDX_W-1:0];
  assign last_bit = (idx == IDX_W'(WORD_W - 1));
  assign last_vec = &x_out;

  // The word as it stands once the current sample lands in its slot.
  always_comb begin
    word_nxt      = shreg;
    word_nxt[idx] = y_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (last_bit) state_nxt = EMIT;
      EMIT:       if (out_ready) state_nxt = last_vec ? DONE : RUN;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // All outputs are registered, so nothing combinational reaches them from y_in or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out      <= '0;
      shreg      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_out      <= '0;
            shreg      <= '0;
            ones_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          shreg      <= word_nxt;
          ones_count <= ones_count + (N_IN + 1)'(y_in);
          if (last_bit) begin
            out_data  <= word_nxt;
            out_valid <= 1'b1;
          end else begin
            x_out <= x_out + N_IN'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_vec) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              x_out <= x_out + N_IN'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_signature_reader.sv
// Bench for tt_signature_reader: the netlist is modelled as a selectable boolean function of x_out,
// expected words and onset counts come straight from evaluating that function.
module tb_tt_signature_reader;

  localparam int N_IN   = 15;
  localparam int WORD_W = 32;
  localparam int NV     = 1 << N_IN;
  localparam int NWORDS = NV / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              y_in;
  logic              out_ready = 1'b0;
  logic [N_IN-1:0]   x_out;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [N_IN:0]     ones_count;

  int mode = 0;
  bit tt[NV];
  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  tt_signature_reader #(.N_IN(N_IN), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .x_out(x_out), .y_in(y_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ones_count(ones_count)
  );

  // Function modes: 0 const0, 1 const1, 2 x0, 3 x5, 4 x1, 5 x4, 6 random table.
  function automatic bit fbit(input int m, input int v);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return v[0];
      3:       return v[5];
      4:       return v[1];
      5:       return v[4];
      default: return tt[v];
    endcase
  endfunction

  assign y_in = fbit(mode, int'(x_out));

  function automatic logic [WORD_W-1:0] exp_word(input int m, input int k);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W; i++) w[i] = fbit(m, k * WORD_W + i);
    return w;
  endfunction

  function automatic int exp_ones(input int m, input int nvec);
    int s = 0;
    for (int v = 0; v < nvec; v++) s += int'(fbit(m, v));
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called on a negedge; raises start and measures cycles until the first word appears.
  task automatic start_sweep(input string tag);
    int n = 0;
    out_ready = 1'b0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!out_valid && n < 100);
    chk({tag, "_latency"}, 64'(n), 64'd33);
  endtask

  // Called on a negedge; returns once a word has been handshaken (or the bound expires).
  task automatic get_word(input bit rnd, output logic [WORD_W-1:0] w, output bit ok);
    int cyc = 0;
    ok = 1'b0;
    w = 'x;
    while (!ok && cyc < 300) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        w = out_data;
        ok = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int                m;
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", npass, ntotal);
    $fatal(1);
  end

  initial begin
    vec_t              tbl[6];
    logic [WORD_W-1:0] w;
    bit                ok;
    int                errs;

    for (int v = 0; v < NV; v++) tt[v] = 1'($urandom_range(0, 1));

    tbl[0] = '{0, 32'h0000_0000, 32'h0000_0000};
    tbl[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2] = '{2, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
    tbl[3] = '{3, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[4] = '{4, 32'hCCCC_CCCC, 32'hCCCC_CCCC};
    tbl[5] = '{5, 32'hFFFF_0000, 32'hFFFF_0000};

    // Reset state
    #1 rst = 1'b1;
    #10;
    chk("rst_x_out", 64'(x_out), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ones", 64'(ones_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: first two words of a sweep for simple functions
    foreach (tbl[t]) begin
      do_reset();
      mode = tbl[t].m;
      start_sweep($sformatf("tbl%0d", t));
      get_word(1'b0, w, ok);
      chk($sformatf("tbl%0d_w0", t), 64'(w), 64'(tbl[t].w0));
      get_word(1'b0, w, ok);
      chk($sformatf("tbl%0d_w1", t), 64'(w), 64'(tbl[t].w1));
      chk($sformatf("tbl%0d_ones64", t), 64'(ones_count), 64'(exp_ones(mode, 64)));
      chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'd1);
    end

    // Backpressure on word 3 with y = x0
    do_reset();
    mode = 2;
    start_sweep("stall");
    for (int k = 0; k < 3; k++) begin
      get_word(1'b0, w, ok);
      chk($sformatf("stall_w%0d", k), 64'(w), 64'h0000_0000_AAAA_AAAA);
    end
    out_ready = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("stall_data", 64'(out_data), 64'h0000_0000_AAAA_AAAA);
      chk("stall_x", 64'(x_out), 64'd127);
      chk("stall_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    get_word(1'b0, w, ok);
    chk("stall_w3", 64'(w), 64'h0000_0000_AAAA_AAAA);
    get_word(1'b0, w, ok);
    chk("stall_w4", 64'(w), 64'h0000_0000_AAAA_AAAA);
    chk("stall_x_after", 64'(x_out), 64'd160);

    // Reset during word 10, then restart with start pulses while busy
    do_reset();
    mode = 6;
    start_sweep("mid");
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      get_word(1'b1, w, ok);
      if (!ok || w !== exp_word(6, k)) errs++;
    end
    chk("mid_pre_words", 64'(errs), 64'd0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x", 64'(x_out), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ones", 64'(ones_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_idle_busy", 64'(busy), 64'd0);
    start_sweep("mid2");
    get_word(1'b0, w, ok);
    chk("mid2_w0", 64'(w), 64'(exp_word(6, 0)));
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid2_ignored_x", 64'(x_out), 64'd38);
    get_word(1'b0, w, ok);
    chk("mid2_w1", 64'(w), 64'(exp_word(6, 1)));
    out_ready = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(negedge clk);
      start = (n == 3);
    end
    start = 1'b0;
    get_word(1'b0, w, ok);
    chk("mid2_w2", 64'(w), 64'(exp_word(6, 2)));

    // Full sweep of a random function with random backpressure
    do_reset();
    mode = 6;
    start_sweep("rsw");
    errs = 0;
    for (int k = 0; k < NWORDS; k++) begin
      get_word(1'b1, w, ok);
      if (!ok || w !== exp_word(6, k)) errs++;
    end
    chk("rsw_words", 64'(errs), 64'd0);
    chk("rsw_done", 64'(done), 64'd1);
    chk("rsw_busy", 64'(busy), 64'd0);
    chk("rsw_valid", 64'(out_valid), 64'd0);
    chk("rsw_x", 64'(x_out), 64'(NV - 1));
    chk("rsw_ones", 64'(ones_count), 64'(exp_ones(6, NV)));
    repeat (20) @(negedge clk);
    chk("rsw_done_hold", 64'(done), 64'd1);
    chk("rsw_ones_hold", 64'(ones_count), 64'(exp_ones(6, NV)));
    chk("rsw_x_hold", 64'(x_out), 64'(NV - 1));

    // Restart from DONE with y tied 1: maximum onset
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("one_start_busy", 64'(busy), 64'd1);
    chk("one_start_done", 64'(done), 64'd0);
    chk("one_start_x", 64'(x_out), 64'd0);
    chk("one_start_ones", 64'(ones_count), 64'd0);
    errs = 0;
    for (int k = 0; k < NWORDS; k++) begin
      get_word(1'b0, w, ok);
      if (!ok || w !== '1) errs++;
    end
    chk("one_words", 64'(errs), 64'd0);
    chk("one_ones", 64'(ones_count), 64'h8000);
    chk("one_done", 64'(done), 64'd1);
    chk("one_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
